// File: rtl/sd_sdram_copy_pkg.sv
// Shared definitions for the SD-to-SDRAM copy sequencer.
//   - copy_state_e       : sequencer states
//   - WORDS_PER_SEC_DEF  : default 16-bit words per 512-byte sector
//   - TIMEOUT_CYCLES_DEF : default no-progress watchdog limit (clk_sd cycles)
//   - WCNT_W             : width of the per-sector word counter
package sd_sdram_copy_pkg;

  localparam int unsigned WORDS_PER_SEC_DEF  = 256;
  localparam int unsigned TIMEOUT_CYCLES_DEF = 2_000_000;
  localparam int unsigned WCNT_W             = 9;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_ISSUE,
    ST_XFER,
    ST_NEXT,
    ST_DONE,
    ST_ERROR
  } copy_state_e;

endpackage

// File: rtl/sd_sdram_copy_ctrl_watchdog.sv
// copy_watchdog: loadable no-progress down-counter.
//   clk_i     : clock
//   rst_i     : synchronous active-high reset (counter to 0)
//   clear_i   : reload to LIMIT-1 (takes priority over enable_i)
//   enable_i  : count down one step per cycle, saturating at 0
//   expired_o : counter has reached 0; after a clear, this happens once
//               enable_i has been high for LIMIT cycles
module copy_watchdog #(
  parameter int unsigned LIMIT = 2_000_000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int unsigned     CNT_W    = (LIMIT > 1) ? $clog2(LIMIT) : 1;
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(LIMIT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = LOAD_VAL;
    end else if (enable_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/sd_sdram_copy_ctrl.sv
// sd_sdram_copy_ctrl: copies sec_count consecutive SD sectors, starting at
// sec_addr_base, into the SDRAM write FIFO. Each 16-bit SD read word is
// forwarded with one registered cycle of latency.
// Optional feature: define COPY_CHECKSUM_EN to add the `checksum` output
// (16-bit wrap-around sum of all forwarded words of the job).
// Ports:
//   clk_sd, reset                 : clock, synchronous active-high reset
//   start, sec_addr_base, sec_count : job request and its parameters
//   sd_init_done, sdram_init_done : start is accepted only when both are 1
//   sd_rd_busy/en/data            : SD controller read port (inputs)
//   sd_rd_start_en, sd_rd_sec_addr: SD read request and sector address
//   sdram_wr_load/en/data         : SDRAM write FIFO control and data
//   busy, done, error, sec_done   : job status
module sd_sdram_copy_ctrl
  import sd_sdram_copy_pkg::*;
#(
  parameter int unsigned WORDS_PER_SEC  = WORDS_PER_SEC_DEF,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic        clk_sd,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] sec_addr_base,
  input  logic [15:0] sec_count,
  input  logic        sd_init_done,
  input  logic        sdram_init_done,
  input  logic        sd_rd_busy,
  input  logic        sd_rd_en,
  input  logic [15:0] sd_rd_data,
  output logic        sd_rd_start_en,
  output logic [31:0] sd_rd_sec_addr,
  output logic        sdram_wr_load,
  output logic        sdram_wr_en,
  output logic [15:0] sdram_wr_data,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [15:0] sec_done
`ifdef COPY_CHECKSUM_EN
  ,
  output logic [15:0] checksum
`endif
);

  localparam logic [WCNT_W-1:0] WORDS_LIM = WCNT_W'(WORDS_PER_SEC);

  copy_state_e       state_q, state_d;
  logic [31:0]       addr_q;
  logic [15:0]       count_q;
  logic [15:0]       sec_done_q;
  logic [WCNT_W-1:0] wcnt_q;
  logic [WCNT_W-1:0] wcnt_inc;
  logic              error_q;
  logic              wr_en_q;
  logic [15:0]       wr_data_q;
  logic              accept;
  logic              overflow;
  logic              fwd;
  logic              wd_clear, wd_enable, wd_expired;

  assign accept   = (state_q == ST_IDLE) && start && sd_init_done && sdram_init_done;
  // A word arriving when the sector is already full is an error, not data.
  assign overflow = (state_q == ST_XFER) && sd_rd_en && (wcnt_q == WORDS_LIM);
  assign fwd      = (state_q == ST_XFER) && sd_rd_en && (wcnt_q != WORDS_LIM);
  // Count the word of this cycle before judging a busy fall in the same cycle.
  assign wcnt_inc = wcnt_q + WCNT_W'(sd_rd_en);

  assign wd_enable = (state_q == ST_ISSUE) || (state_q == ST_XFER);
  assign wd_clear  = (state_d != state_q) || sd_rd_en;

  copy_watchdog #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk_i    (clk_sd),
    .rst_i    (reset),
    .clear_i  (wd_clear),
    .enable_i (wd_enable),
    .expired_o(wd_expired)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (accept) state_d = ST_LOAD;
      ST_LOAD:  state_d = (count_q == '0) ? ST_DONE : ST_ISSUE;
      ST_ISSUE: begin
        if (sd_rd_busy)      state_d = ST_XFER;
        else if (wd_expired) state_d = ST_ERROR;
      end
      ST_XFER: begin
        if (overflow)                    state_d = ST_ERROR;
        else if (!sd_rd_busy)            state_d = (wcnt_inc == WORDS_LIM) ? ST_NEXT : ST_ERROR;
        else if (wd_expired && !sd_rd_en) state_d = ST_ERROR;
      end
      ST_NEXT:  state_d = ((sec_done_q + 16'd1) == count_q) ? ST_DONE : ST_ISSUE;
      ST_DONE:  state_d = ST_IDLE;
      ST_ERROR: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_sd) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      count_q    <= '0;
      sec_done_q <= '0;
      wcnt_q     <= '0;
      error_q    <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_data_q  <= '0;
    end else begin
      state_q <= state_d;
      wr_en_q <= fwd;
      if (fwd) wr_data_q <= sd_rd_data;

      if (accept) begin
        addr_q     <= sec_addr_base;
        count_q    <= sec_count;
        sec_done_q <= '0;
        error_q    <= 1'b0;
      end

      if ((state_q == ST_LOAD) || (state_q == ST_NEXT)) begin
        wcnt_q <= '0;
      end else if (fwd) begin
        wcnt_q <= wcnt_q + WCNT_W'(1);
      end

      if (state_q == ST_NEXT) begin
        sec_done_q <= sec_done_q + 16'd1;
        addr_q     <= addr_q + 32'd1;
      end

      // Set on the edge that enters ERROR so the flag rises with that state.
      if (state_d == ST_ERROR) error_q <= 1'b1;
    end
  end

`ifdef COPY_CHECKSUM_EN
  logic [15:0] sum_q;

  always_ff @(posedge clk_sd) begin
    if (reset) begin
      sum_q <= '0;
    end else if (accept) begin
      sum_q <= '0;
    end else if (fwd) begin
      sum_q <= sum_q + sd_rd_data;
    end
  end

  assign checksum = sum_q;
`endif

  assign sd_rd_start_en = (state_q == ST_ISSUE);
  assign sd_rd_sec_addr = addr_q;
  assign sdram_wr_load  = (state_q == ST_LOAD);
  assign sdram_wr_en    = wr_en_q;
  assign sdram_wr_data  = wr_data_q;
  assign busy           = (state_q != ST_IDLE);
  assign done           = (state_q == ST_DONE);
  assign error          = error_q;
  assign sec_done       = sec_done_q;

endmodule

// File: tb/tb_sd_sdram_copy_ctrl.sv
// Directed bench for sd_sdram_copy_ctrl with a behavioural SD read model.
module tb_sd_sdram_copy_ctrl;

  logic        clk_sd = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] sec_addr_base;
  logic [15:0] sec_count;
  logic        sd_init_done;
  logic        sdram_init_done;
  logic        sd_rd_busy;
  logic        sd_rd_en;
  logic [15:0] sd_rd_data;
  logic        sd_rd_start_en;
  logic [31:0] sd_rd_sec_addr;
  logic        sdram_wr_load;
  logic        sdram_wr_en;
  logic [15:0] sdram_wr_data;
  logic        busy;
  logic        done;
  logic        error;
  logic [15:0] sec_done;
`ifdef COPY_CHECKSUM_EN
  logic [15:0] checksum;
`endif

  always #5 clk_sd = ~clk_sd;

  sd_sdram_copy_ctrl #(
    .WORDS_PER_SEC (256),
    .TIMEOUT_CYCLES(100)
  ) dut (
    .clk_sd         (clk_sd),
    .reset          (reset),
    .start          (start),
    .sec_addr_base  (sec_addr_base),
    .sec_count      (sec_count),
    .sd_init_done   (sd_init_done),
    .sdram_init_done(sdram_init_done),
    .sd_rd_busy     (sd_rd_busy),
    .sd_rd_en       (sd_rd_en),
    .sd_rd_data     (sd_rd_data),
    .sd_rd_start_en (sd_rd_start_en),
    .sd_rd_sec_addr (sd_rd_sec_addr),
    .sdram_wr_load  (sdram_wr_load),
    .sdram_wr_en    (sdram_wr_en),
    .sdram_wr_data  (sdram_wr_data),
    .busy           (busy),
    .done           (done),
    .error          (error),
    .sec_done       (sec_done)
`ifdef COPY_CHECKSUM_EN
    ,
    .checksum       (checksum)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // SD read model controls
  logic model_on     = 1'b1;
  logic model_active = 1'b0;
  logic const_mode   = 1'b0;
  int   sec_idx      = 0;
  int   short_sec    = -1;

  always begin
    logic [31:0] a;
    int          nw;
    @(negedge clk_sd);
    if (model_on && sd_rd_start_en && !model_active) begin
      model_active = 1'b1;
      a  = sd_rd_sec_addr;
      nw = (sec_idx == short_sec) ? 255 : 256;
      sec_idx++;
      sd_rd_busy = 1'b1;
      for (int i = 0; i < nw; i++) begin
        @(negedge clk_sd);
        sd_rd_en   = 1'b1;
        sd_rd_data = const_mode ? 16'h0101 : {a[7:0], 8'(i)};
      end
      @(negedge clk_sd);
      sd_rd_en   = 1'b0;
      sd_rd_data = '0;
      sd_rd_busy = 1'b0;
      @(negedge clk_sd);
      model_active = 1'b0;
    end
  end

  // Monitor
  logic        mon_en = 1'b1;
  int          wr_cnt, load_cnt, done_cnt, rise_cnt, lat_err;
  logic [15:0] done_secs;
  logic [31:0] addr_log[$];
  logic        prev_se = 1'b0;
  logic        pe = 1'b0;
  logic [15:0] pd = '0;

  always @(posedge clk_sd) begin
    pe = sd_rd_en;
    pd = sd_rd_data;
  end

  always @(negedge clk_sd) begin
    if (mon_en) begin
      if (sdram_wr_en) wr_cnt++;
      if (sdram_wr_load) load_cnt++;
      if (done) begin
        done_cnt++;
        done_secs = sec_done;
      end
      if (sd_rd_start_en && !prev_se) begin
        rise_cnt++;
        addr_log.push_back(sd_rd_sec_addr);
      end
      if (sdram_wr_en !== pe) lat_err++;
      else if (pe && (sdram_wr_data !== pd)) lat_err++;
    end
    prev_se = sd_rd_start_en;
  end

  task automatic clear_stats();
    wr_cnt = 0; load_cnt = 0; done_cnt = 0; rise_cnt = 0; lat_err = 0;
    done_secs = '0;
    addr_log.delete();
    sec_idx = 0;
  endtask

  // Called at a negedge; returns at the negedge of cycle 1.
  task automatic pulse_start(input logic [31:0] b, input logic [15:0] c);
    sec_addr_base = b;
    sec_count     = c;
    start         = 1'b1;
    @(negedge clk_sd);
    start = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 5000) begin
      @(negedge clk_sd);
      n++;
    end
    chk(tag, 32'(busy), 32'd0);
  endtask

  task automatic wait_model(input string tag);
    int n = 0;
    while (model_active && n < 2000) begin
      @(negedge clk_sd);
      n++;
    end
    chk(tag, 32'(model_active), 32'd0);
  endtask

  initial begin
    int err_cyc;
    reset = 1'b1; start = 1'b0; sec_addr_base = '0; sec_count = '0;
    sd_init_done = 1'b1; sdram_init_done = 1'b1;
    sd_rd_busy = 1'b0; sd_rd_en = 1'b0; sd_rd_data = '0;
    clear_stats();
    repeat (3) @(negedge clk_sd);
    reset = 1'b0;
    @(negedge clk_sd);

    // Reset state
    chk("rst_busy",  32'(busy), 32'd0);
    chk("rst_done",  32'(done), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    chk("rst_secd",  32'(sec_done), 32'd0);
    chk("rst_rdst",  32'(sd_rd_start_en), 32'd0);
    chk("rst_load",  32'(sdram_wr_load), 32'd0);
    chk("rst_addr",  sd_rd_sec_addr, 32'd0);

    // Zero count
    clear_stats();
    pulse_start(32'h200, 16'd0);
    chk("zc_busy_c1", 32'(busy), 32'd1);
    chk("zc_load_c1", 32'(sdram_wr_load), 32'd1);
    @(negedge clk_sd);
    chk("zc_done_c2", 32'(done), 32'd1);
    chk("zc_load_c2", 32'(sdram_wr_load), 32'd0);
    @(negedge clk_sd);
    chk("zc_busy_c3", 32'(busy), 32'd0);
    chk("zc_no_rd",   32'(rise_cnt), 32'd0);
    chk("zc_loads",   32'(load_cnt), 32'd1);

    // Happy path, with an ignored start mid-job
    clear_stats();
    pulse_start(32'h100, 16'd3);
    chk("hp_load_c1", 32'(sdram_wr_load), 32'd1);
    chk("hp_busy_c1", 32'(busy), 32'd1);
    chk("hp_addr_c1", sd_rd_sec_addr, 32'h100);
    @(negedge clk_sd);
    chk("hp_rdst_c2", 32'(sd_rd_start_en), 32'd1);
    repeat (300) @(negedge clk_sd);
    pulse_start(32'h5000, 16'd1);
    wait_idle("hp_idle");
    wait_model("hp_model");
    chk("hp_reads",   32'(rise_cnt), 32'd3);
    chk("hp_addr0",   addr_log[0], 32'h100);
    chk("hp_addr1",   addr_log[1], 32'h101);
    chk("hp_addr2",   addr_log[2], 32'h102);
    chk("hp_wr_cnt",  32'(wr_cnt), 32'd768);
    chk("hp_loads",   32'(load_cnt), 32'd1);
    chk("hp_dones",   32'(done_cnt), 32'd1);
    chk("hp_done_sd", 32'(done_secs), 32'd3);
    chk("hp_secd",    32'(sec_done), 32'd3);
    chk("hp_error",   32'(error), 32'd0);
    chk("hp_latency", 32'(lat_err), 32'd0);

    // Short second sector
    clear_stats();
    short_sec = 1;
    pulse_start(32'h300, 16'd3);
    wait_idle("sh_idle");
    wait_model("sh_model");
    short_sec = -1;
    chk("sh_error",  32'(error), 32'd1);
    chk("sh_secd",   32'(sec_done), 32'd1);
    chk("sh_dones",  32'(done_cnt), 32'd0);
    chk("sh_wr_cnt", 32'(wr_cnt), 32'd511);
    chk("sh_reads",  32'(rise_cnt), 32'd2);

    // Gating: start ignored without both init flags, error unchanged
    clear_stats();
    sdram_init_done = 1'b0;
    pulse_start(32'h400, 16'd1);
    chk("g1_busy", 32'(busy), 32'd0);
    @(negedge clk_sd);
    chk("g1_busy2", 32'(busy), 32'd0);
    chk("g1_err_kept", 32'(error), 32'd1);
    sdram_init_done = 1'b1;
    sd_init_done = 1'b0;
    pulse_start(32'h400, 16'd1);
    chk("g2_busy", 32'(busy), 32'd0);
    sd_init_done = 1'b1;
    @(negedge clk_sd);
    chk("g_loads", 32'(load_cnt), 32'd0);

    // Address wrap-around
    clear_stats();
    pulse_start(32'hFFFF_FFFF, 16'd2);
    chk("wr_err_clr", 32'(error), 32'd0);
    wait_idle("wr_idle");
    wait_model("wr_model");
    chk("wr_reads",  32'(rise_cnt), 32'd2);
    chk("wr_addr0",  addr_log[0], 32'hFFFF_FFFF);
    chk("wr_addr1",  addr_log[1], 32'h0000_0000);
    chk("wr_secd",   32'(sec_done), 32'd2);
    chk("wr_dones",  32'(done_cnt), 32'd1);
    chk("wr_wr_cnt", 32'(wr_cnt), 32'd512);

    // Timeout: busy never rises
    clear_stats();
    model_on = 1'b0;
    pulse_start(32'h10, 16'd1);
    err_cyc = -1;
    for (int c = 1; c < 400; c++) begin
      if ((error === 1'b1) && (err_cyc < 0)) err_cyc = c;
      if ((err_cyc >= 0) && !busy) break;
      @(negedge clk_sd);
    end
    chk("to_err_cycle", 32'(err_cyc), 32'd102);
    chk("to_busy",  32'(busy), 32'd0);
    chk("to_dones", 32'(done_cnt), 32'd0);
    model_on = 1'b1;

    // Reset in the middle of XFER
    clear_stats();
    pulse_start(32'h20, 16'd1);
    for (int n = 0; n < 50 && !sdram_wr_en; n++) @(negedge clk_sd);
    chk("rm_wr_seen", 32'(sdram_wr_en), 32'd1);
    repeat (5) @(negedge clk_sd);
    mon_en = 1'b0;
    reset = 1'b1;
    @(negedge clk_sd);
    chk("rm_busy",  32'(busy), 32'd0);
    chk("rm_rdst",  32'(sd_rd_start_en), 32'd0);
    chk("rm_wren",  32'(sdram_wr_en), 32'd0);
    chk("rm_wdata", 32'(sdram_wr_data), 32'd0);
    chk("rm_load",  32'(sdram_wr_load), 32'd0);
    chk("rm_done",  32'(done), 32'd0);
    chk("rm_secd",  32'(sec_done), 32'd0);
    chk("rm_addr",  sd_rd_sec_addr, 32'd0);
    reset = 1'b0;
    wait_model("rm_model");
    chk("rm_idle", 32'(busy), 32'd0);
    mon_en = 1'b1;

`ifdef COPY_CHECKSUM_EN
    clear_stats();
    const_mode = 1'b1;
    pulse_start(32'h30, 16'd1);
    wait_idle("cs_idle");
    wait_model("cs_model");
    const_mode = 1'b0;
    chk("cs_sum",   32'(checksum), 32'h0100);
    chk("cs_dones", 32'(done_cnt), 32'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sd_sdram_copy_ctrl.md
# sd_sdram_copy_ctrl

Sequencer that copies a run of consecutive SD-card sectors into SDRAM. It issues sector reads to the SD SPI controller and forwards every 16-bit read word into the SDRAM write FIFO, clearing the FIFO and write address at job start. It reports sector progress, completion and errors. It sits between `sd_spi_controller` (read port) and `sdram_top` (write FIFO port), replacing the free-running SD data generator when a copy job is needed.

## Interface
- `WORDS_PER_SEC`, 256: 16-bit words per 512-byte sector.
- `TIMEOUT_CYCLES`, 2_000_000: no-progress watchdog limit in `clk_sd` cycles (100 ms at 20 MHz).
- `clk_sd`  in  1  sole clock; SD controller and SDRAM FIFO write side both run on it.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle job request.
- `sec_addr_base`  in  32  first SD sector address; sampled at accepted `start`.
- `sec_count`  in  16  number of sectors; sampled at accepted `start`.
- `sd_init_done`  in  1  SD card ready.
- `sdram_init_done`  in  1  SDRAM ready.
- `sd_rd_busy`  in  1  SD read in progress.
- `sd_rd_en`  in  1  SD read word valid.
- `sd_rd_data`  in  16  SD read word.
- `sd_rd_start_en`  out  1  SD read request.
- `sd_rd_sec_addr`  out  32  SD read sector address.
- `sdram_wr_load`  out  1  clears SDRAM write address and FIFO.
- `sdram_wr_en`  out  1  SDRAM FIFO write strobe.
- `sdram_wr_data`  out  16  SDRAM FIFO write word.
- `busy`  out  1  job active.
- `done`  out  1  one-cycle pulse when a job completes successfully.
- `error`  out  1  sticky job-failure flag.
- `sec_done`  out  16  sectors completed in the current or last job.
- `checksum`  out  16  only with `COPY_CHECKSUM_EN`.

## Operation
- Reset: state IDLE; all outputs 0; internal counters 0.
- **IDLE**
  - `start` is accepted only if `sd_init_done && sdram_init_done`. Otherwise it is ignored, with no flag change.
  - On an accepted start: latch `sec_addr_base` and `sec_count`, clear `error`, `sec_done` and `checksum`, then go to LOAD.
- **LOAD**: `sdram_wr_load`=1 for exactly one cycle.
  - If `sec_count`==0, go to DONE.
  - Otherwise `sd_rd_sec_addr` = base and go to ISSUE.
- **ISSUE**: hold `sd_rd_start_en`=1 until `sd_rd_busy`=1 is sampled. Then drop it and go to XFER.
- **XFER**
  - Each `sd_rd_en`=1 cycle increments the 9-bit word counter and forwards the word.
  - When `sd_rd_busy` falls:
    - word count == `WORDS_PER_SEC`: go to NEXT.
    - any other count: go to ERROR.
  - A 257th `sd_rd_en` in one sector goes to ERROR immediately, and that word is not forwarded.
- **NEXT**: `sec_done`+1, address+1 (wraps mod 2^32), word counter cleared.
  - If `sec_done` now equals `sec_count`, go to DONE; else go to ISSUE.
- **DONE**: `done`=1 for one cycle, then IDLE.
- **ERROR**: `error`=1 (held until the next accepted `start` or reset), then IDLE. `sec_done` freezes at the count reached.
- **Watchdog**
  - Counts cycles in ISSUE and XFER; cleared on each state entry and on each `sd_rd_en`.
  - Reaching `TIMEOUT_CYCLES` goes to ERROR.
- `start` while `busy` is ignored.
- Reset mid-job: aborts immediately. No `done`; `sd_rd_start_en` and `sdram_wr_en` drop in the next cycle.

## Timing
- `start` at cycle 0: `busy`=1 and `sdram_wr_load`=1 at cycle 1, `sd_rd_start_en`=1 at cycle 2.
- `busy` is 1 in every state except IDLE.
- Forwarding latency is 1 cycle. `sd_rd_en`/`sd_rd_data` at cycle n gives `sdram_wr_en`/`sdram_wr_data` at n+1, both registered.
- `sdram_wr_en` never asserts outside XFER plus its one-cycle drain.
- `sd_rd_sec_addr` is stable from one cycle before `sd_rd_start_en` rises until NEXT.
- `sec_done` updates in the NEXT cycle. `done` coincides with the final `sec_done` value.
- A `sd_rd_busy` fall in the same cycle as the last `sd_rd_en`: the word is counted first, then the count is checked.

## Configuration
- `COPY_CHECKSUM_EN` defined:
  - `checksum` port present; 16-bit wrap-around sum of all forwarded words of the job.
  - Cleared at accepted `start`; valid when `done` pulses.
- `COPY_CHECKSUM_EN` undefined: port and adder absent; all other behaviour identical.

## Structure
- Shared package `sd_sdram_copy_pkg`:
  - state enum (IDLE, LOAD, ISSUE, XFER, NEXT, DONE, ERROR);
  - `WORDS_PER_SEC_DEF` and `TIMEOUT_CYCLES_DEF`;
  - word-counter width constant (9).
- One sub-module, `copy_watchdog`: loadable down-counter with `clear`, `enable` and `expired`.

## Test plan
- Happy path:
  - Stimulus: `sec_addr_base`=0x100, `sec_count`=3; SD model returns 256 words per sector, data = address index.
  - Response: read addresses 0x100, 0x101, 0x102; 768 `sdram_wr_en` pulses with data intact; one `sdram_wr_load`; `done` once; `sec_done`=3; `error`=0.
- Zero count: `sec_count`=0 -> `sdram_wr_load` pulse, `done` at cycle 2, no `sd_rd_start_en`.
- Short sector: model gives 255 words in sector 2 -> `error`=1, `sec_done`=1, no `done`.
- Timeout: `sd_rd_busy` never rises, `TIMEOUT_CYCLES`=100 -> ERROR at cycle 102 ±1; `busy`=0 afterwards.
- Gating and wrap-around:
  - `start` with `sdram_init_done`=0 -> ignored, `busy` stays 0.
  - `start` mid-job -> ignored.
  - Base 0xFFFF_FFFF, count 2 -> second read address 0x0000_0000.
- Checksum (`COPY_CHECKSUM_EN`): all words 0x0101 over 1 sector -> `checksum`=0x0100. Also assert reset mid-XFER -> all outputs 0 next cycle.
